// File: rtl/beep_sequencer.sv
// Queued square-wave tone generator: notes {code, dur, duty} are pushed into a
// FIFO and played one at a time on a registered buzzer output, each followed by a silent gap.
module beep_sequencer #(
    parameter int DIV_W    = 18,
    parameter int DUR_W    = 4,
    parameter int UNIT_MAX = 24_999_999,
    parameter int GAP_LEN  = 2_500_000,
    parameter int DEPTH    = 8,
    parameter int NOTE1    = 190839,
    parameter int NOTE2    = 170067,
    parameter int NOTE3    = 151415,
    parameter int NOTE4    = 143265,
    parameter int NOTE5    = 127550,
    parameter int NOTE6    = 113635,
    parameter int NOTE7    = 101214
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     stop,
    input  logic                     note_valid,
    output logic                     note_ready,
    input  logic [2:0]               note_code,
    input  logic [DUR_W-1:0]         note_dur,
    input  logic [1:0]               duty_sel,
    output logic                     beep,
    output logic                     busy,
    output logic                     note_done,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int UNIT_W = (UNIT_MAX > 0) ? $clog2(UNIT_MAX + 1) : 1;
    localparam int GAP_W  = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_MAX);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam bit NO_GAP = (GAP_LEN == 0);

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

    typedef struct packed {
        logic [2:0]       code;
        logic [DUR_W-1:0] dur;
        logic [1:0]       duty;
    } note_t;

    state_t state, next_state;

    note_t            mem [DEPTH];
    note_t            cur;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             push, pop, full;

    logic [DIV_W-1:0]  period, thresh, freq_cnt;
    logic [DIV_W-1:0]  load_period, load_thresh;
    logic [UNIT_W-1:0] unit_cnt;
    logic [DUR_W-1:0]  dur, dur_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic              play_last, gap_last, done_evt;

    assign full       = (count == (PTR_W + 1)'(DEPTH));
    assign note_ready = !full && !stop && !sys_rst;
    assign push       = note_valid && note_ready;
    // A fresh push is invisible to the pop until count has been updated.
    assign pop        = (state == IDLE) && (count != '0) && !stop && !sys_rst;
    assign busy       = (state != IDLE) || (count != '0);
    assign fifo_level = count;

    assign play_last = (unit_cnt == UNIT_LAST) && (dur_cnt == dur - DUR_W'(1));
    assign gap_last  = (gap_cnt == GAP_LAST);
    assign done_evt  = ((state == PLAY) && play_last && NO_GAP) ||
                       ((state == GAP) && gap_last);

    always_comb begin
        load_period = DIV_W'(NOTE1);
        case (cur.code)
            3'd2:    load_period = DIV_W'(NOTE2);
            3'd3:    load_period = DIV_W'(NOTE3);
            3'd4:    load_period = DIV_W'(NOTE4);
            3'd5:    load_period = DIV_W'(NOTE5);
            3'd6:    load_period = DIV_W'(NOTE6);
            3'd7:    load_period = DIV_W'(NOTE7);
            default: load_period = DIV_W'(NOTE1);
        endcase
        load_thresh = load_period - (load_period >> (3'(cur.duty) + 3'd1));
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (count != '0) next_state = LOAD;
            LOAD:    next_state = PLAY;
            PLAY:    if (play_last) next_state = NO_GAP ? IDLE : GAP;
            GAP:     if (gap_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (stop) next_state = IDLE;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= next_state;
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= '{code: note_code, dur: note_dur, duty: duty_sel};
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || stop) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            beep      <= 1'b0;
            note_done <= 1'b0;
            freq_cnt  <= '0;
            unit_cnt  <= '0;
            dur_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                cur    <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            beep      <= (state == PLAY) && (cur.code != 3'd0) && (freq_cnt >= thresh);
            note_done <= done_evt;
            case (state)
                LOAD: begin
                    period   <= load_period;
                    thresh   <= load_thresh;
                    dur      <= (cur.dur == '0) ? DUR_W'(1) : cur.dur;
                    freq_cnt <= '0;
                    unit_cnt <= '0;
                    dur_cnt  <= '0;
                    gap_cnt  <= '0;
                end
                PLAY: begin
                    freq_cnt <= (freq_cnt == period) ? '0 : freq_cnt + 1'b1;
                    if (unit_cnt == UNIT_LAST) begin
                        unit_cnt <= '0;
                        dur_cnt  <= dur_cnt + 1'b1;
                    end else begin
                        unit_cnt <= unit_cnt + 1'b1;
                    end
                end
                GAP:     gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_beep_sequencer.sv
// Directed bench for beep_sequencer: a table of single notes with hand-derived
// timing, plus sequences for FIFO full, stop mid-note and reset mid-gap.
module tb_beep_sequencer;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       stop;
    logic       note_valid;
    logic       note_ready;
    logic [2:0] note_code;
    logic [3:0] note_dur;
    logic [1:0] duty_sel;
    logic       beep;
    logic       busy;
    logic       note_done;
    logic [2:0] fifo_level;

    int checks   = 0;
    int failures = 0;

    beep_sequencer #(
        .DIV_W(18), .DUR_W(4), .UNIT_MAX(9), .GAP_LEN(2), .DEPTH(4),
        .NOTE1(19), .NOTE2(15)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .stop(stop),
        .note_valid(note_valid), .note_ready(note_ready),
        .note_code(note_code), .note_dur(note_dur), .duty_sel(duty_sel),
        .beep(beep), .busy(busy), .note_done(note_done), .fifo_level(fifo_level)
    );

    always #5 sys_clk = ~sys_clk;

    // k counts edges after the accepting edge; highs are the samples with beep=1.
    typedef struct {
        logic [2:0] code;
        logic [3:0] dur;
        logic [1:0] duty;
        int         done_k;
        int         highs;
        int         first;
        int         last;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run_note(input vec_t v, input int idx);
        int high, first, last, done_k, pulses, lim;
        high = 0; first = 0; last = 0; done_k = 0; pulses = 0;
        note_code = v.code; note_dur = v.dur; duty_sel = v.duty; note_valid = 1'b1;
        #1;
        chk($sformatf("v%0d ready", idx), note_ready, 1);
        tick();
        note_valid = 1'b0;
        chk($sformatf("v%0d level", idx), fifo_level, 1);
        chk($sformatf("v%0d busy", idx), busy, 1);
        lim = (v.done_k + 3 < 300) ? v.done_k + 3 : 300;
        for (int k = 1; k <= lim; k++) begin
            tick();
            if (beep) begin
                high++;
                if (first == 0) first = k;
                last = k;
            end
            if (note_done) begin
                pulses++;
                if (done_k == 0) begin
                    done_k = k;
                    chk($sformatf("v%0d busy at done", idx), busy, 0);
                end
            end
        end
        chk($sformatf("v%0d done_k", idx), done_k, v.done_k);
        chk($sformatf("v%0d highs", idx), high, v.highs);
        chk($sformatf("v%0d first", idx), first, v.first);
        chk($sformatf("v%0d last", idx), last, v.last);
        chk($sformatf("v%0d pulses", idx), pulses, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] fc [5];
        logic [1:0] fd [5];
        int         exp_seg [5];
        int         got_seg [5];
        int         seg, n, pulses, high;

        vecs[0] = '{3'd1, 4'd2,  2'd0, 24,  10, 13, 22};
        vecs[1] = '{3'd2, 4'd1,  2'd1, 14,  0,  0,  0};
        vecs[2] = '{3'd0, 4'd0,  2'd0, 14,  0,  0,  0};
        vecs[3] = '{3'd2, 4'd4,  2'd1, 44,  8,  15, 34};
        vecs[4] = '{3'd1, 4'd2,  2'd3, 24,  2,  21, 22};
        vecs[5] = '{3'd1, 4'd2,  2'd2, 24,  3,  20, 22};
        vecs[6] = '{3'd2, 4'd2,  2'd0, 24,  8,  11, 18};
        vecs[7] = '{3'd1, 4'd15, 2'd0, 154, 70, 13, 142};

        sys_rst = 1'b1; stop = 1'b0; note_valid = 1'b0;
        note_code = '0; note_dur = '0; duty_sel = '0;
        tick(); tick(); tick();
        chk("rst beep", beep, 0);
        chk("rst busy", busy, 0);
        chk("rst done", note_done, 0);
        chk("rst level", fifo_level, 0);
        chk("rst ready", note_ready, 0);
        sys_rst = 1'b0;
        #1;
        chk("post-rst ready", note_ready, 1);

        for (int i = 0; i < 8; i++) begin
            run_note(vecs[i], i);
            tick();
        end

        // FIFO full: five pushes on consecutive edges, the first pops immediately
        fc = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2};
        fd = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_seg = '{10, 5, 3, 2, 8};
        for (int i = 0; i < 5; i++) begin
            note_code = fc[i]; note_dur = 4'd2; duty_sel = fd[i]; note_valid = 1'b1;
            #1;
            chk($sformatf("full push%0d ready", i), note_ready, 1);
            tick();
        end
        note_code = 3'd2; note_dur = 4'd1; duty_sel = 2'd0;
        chk("full level", fifo_level, 4);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("full hold%0d ready", i), note_ready, 0);
            tick();
        end
        chk("full level held", fifo_level, 4);
        note_valid = 1'b0;
        seg = 0; n = 0;
        for (int i = 0; i < 5; i++) got_seg[i] = -1;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (beep) seg++;
            if (note_done) begin
                if (n < 5) got_seg[n] = seg;
                n++;
                seg = 0;
            end
            if (n >= 5 && !busy) break;
        end
        chk("full done count", n, 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("full order%0d highs", i), got_seg[i], exp_seg[i]);
        chk("full drained level", fifo_level, 0);
        tick();

        // stop mid-PLAY with two notes queued
        note_code = 3'd1; note_dur = 4'd2; duty_sel = 2'd0; note_valid = 1'b1;
        tick(); tick(); tick();
        note_valid = 1'b0;
        for (int k = 3; k <= 15; k++) tick();
        chk("stop pre beep", beep, 1);
        chk("stop pre level", fifo_level, 2);
        stop = 1'b1; note_valid = 1'b1;
        #1;
        chk("stop ready", note_ready, 0);
        tick();
        stop = 1'b0; note_valid = 1'b0;
        chk("stop beep", beep, 0);
        chk("stop level", fifo_level, 0);
        chk("stop busy", busy, 0);
        pulses = 0; high = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (note_done) pulses++;
            if (beep) high++;
        end
        chk("stop no done", pulses, 0);
        chk("stop silent", high, 0);
        chk("stop level after", fifo_level, 0);

        // sys_rst while in GAP
        note_code = 3'd1; note_dur = 4'd1; duty_sel = 2'd0; note_valid = 1'b1;
        tick();
        note_valid = 1'b0;
        for (int k = 1; k <= 12; k++) tick();
        chk("gaprst pre busy", busy, 1);
        sys_rst = 1'b1;
        #1;
        chk("gaprst ready", note_ready, 0);
        tick();
        chk("gaprst beep", beep, 0);
        chk("gaprst busy", busy, 0);
        chk("gaprst done", note_done, 0);
        chk("gaprst level", fifo_level, 0);
        tick();
        chk("gaprst no done", note_done, 0);
        sys_rst = 1'b0;
        #1;
        chk("gaprst ready after", note_ready, 1);
        run_note(vecs[0], 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
